// File: rtl/mem_byte_master_if.sv
// Request/response and byte-wide memory bus bundle for mem_byte_master.
// The master modport is the view of the load/store initiator itself; the
// slave modport is the view of everything around it (execute stage + RAM).
interface mem_byte_master_if #(
  parameter int AW = 17
);
  // request side
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_type;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  // response side
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  // byte-wide memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport master (
    input  req_valid, req_we, req_type, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_type, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_byte_master.sv
// Multi-cycle load/store initiator: one word/half/byte access is issued as a
// run of single-byte transfers on a byte-wide synchronous RAM, LSB first.
// Loads are reassembled little-endian and sign/zero extended. All outputs
// are registered; next-state logic computes the value each output must take
// in the cycle after the edge.
module mem_byte_master #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_byte_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_BYTE = 2'b01;
  localparam logic [1:0] TYPE_HALF = 2'b10;
  localparam logic [1:0] TYPE_ILL  = 2'b11;

  // Index of the final beat for a given access size.
  function automatic logic [1:0] last_beat(input logic [1:0] typ);
    case (typ)
      TYPE_WORD: last_beat = 2'd3;
      TYPE_HALF: last_beat = 2'd1;
      TYPE_BYTE: last_beat = 2'd0;
      default:   last_beat = 2'd0;
    endcase
  endfunction

  // Sign/zero extension of an assembled load; words pass through untouched.
  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] raw,
                                                        input logic [1:0] typ,
                                                        input logic uns);
    case (typ)
      TYPE_BYTE: extend_load = uns ? {24'h00_0000, raw[7:0]}
                                   : {{24{raw[7]}}, raw[7:0]};
      TYPE_HALF: extend_load = uns ? {16'h0000, raw[15:0]}
                                   : {{16{raw[15]}}, raw[15:0]};
      TYPE_WORD: extend_load = raw;
      default:   extend_load = raw;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [1:0]               last_q, last_d;
  logic                     we_q, we_d;
  logic [1:0]               type_q, type_d;
  logic                     uns_q, uns_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rbuf_q, rbuf_d;
  logic [DATA_WIDTH-1:0]    rd_asm_s;

  logic                     req_ready_q, req_ready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
  logic                     mem_en_q, mem_en_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BYTE_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  // Next-state and next-output logic for the IDLE/XFER/WAIT/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    we_d         = we_q;
    type_d       = type_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    rd_asm_s     = rbuf_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          type_d      = bus.req_type;
          uns_d       = bus.req_unsigned;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          idx_d       = 2'd0;
          last_d      = last_beat(bus.req_type);
          rbuf_d      = {DATA_WIDTH{1'b0}};
          req_ready_d = 1'b0;
          if (bus.req_type == TYPE_ILL) begin
            // Illegal size: answer immediately, never touch memory.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            // Put beat 0 on the bus in the very next cycle.
            state_d     = ST_XFER;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata[BYTE_WIDTH-1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_XFER: begin
        // Read data for the previous beat arrives one cycle after its enable.
        if (!we_q && (idx_q != 2'd0)) begin
          rbuf_d[{idx_q - 2'd1, 3'b000} +: BYTE_WIDTH] = bus.mem_rdata;
        end else begin
          rbuf_d = rbuf_q;
        end
        if (idx_q == last_q) begin
          if (we_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          // Each byte address wraps independently modulo 2**ADDRESS_WIDTH.
          idx_d       = idx_q + 2'd1;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + {{(ADDRESS_WIDTH-2){1'b0}}, idx_d};
          mem_wdata_d = wdata_q[{idx_d, 3'b000} +: BYTE_WIDTH];
        end
      end

      ST_WAIT: begin
        // Last read byte lands now; finish assembling and extend.
        rd_asm_s[{last_q, 3'b000} +: BYTE_WIDTH] = bus.mem_rdata;
        rbuf_d       = rd_asm_s;
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = extend_load(rd_asm_s, type_q, uns_q);
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State, request latches and registered outputs; reset aborts any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      last_q       <= 2'd0;
      we_q         <= 1'b0;
      type_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= {ADDRESS_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      rbuf_q       <= {DATA_WIDTH{1'b0}};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= {DATA_WIDTH{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDRESS_WIDTH{1'b0}};
      mem_wdata_q  <= {BYTE_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      we_q         <= we_d;
      type_q       <= type_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
